// File: rtl/lo_table_loader_if.sv
// Signal bundle for lo_table_loader: request/status, source-memory read port and LO GPIO write port.
// The loader is the master of the LO write protocol and of the source reads.
interface lo_table_loader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LO_WIDTH   = 18,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  start;
    logic                  tableSelect;
    logic [ADDR_WIDTH-1:0] firstRow;
    logic [ADDR_WIDTH:0]   rowCount;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] srcAddr;
    logic [2*LO_WIDTH-1:0] srcData;
    logic [DATA_WIDTH-1:0] gpioData;
    logic                  localOscillatorAddressStrobe;
    logic                  localOscillatorCsrStrobe;
    logic                  busy;
    logic                  done;
    logic                  errorFlag;
    logic                  abortedFlag;

    modport master (
        input  start, tableSelect, firstRow, rowCount, abort, srcData,
        output srcAddr, gpioData, localOscillatorAddressStrobe, localOscillatorCsrStrobe,
               busy, done, errorFlag, abortedFlag
    );

    modport slave (
        output start, tableSelect, firstRow, rowCount, abort, srcData,
        input  srcAddr, gpioData, localOscillatorAddressStrobe, localOscillatorCsrStrobe,
               busy, done, errorFlag, abortedFlag
    );
endinterface

// File: rtl/lo_table_loader.sv
// Streams an LO table from source memory to the LO GPIO port: one address word, then a
// sign-extended COS and SIN word per row, each strobe followed by a fixed idle gap.
module lo_table_loader #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LO_WIDTH     = 18,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned ROW_CAPACITY = 1024,
    parameter int unsigned STROBE_GAP   = 2,
    parameter int unsigned SRC_LATENCY  = 1
) (
    input logic               clk,
    input logic               reset,
    lo_table_loader_if.master bus
);
    localparam int unsigned GapW = $clog2(STROBE_GAP + 1);

    typedef enum logic [2:0] {StIdle, StAddr, StGap, StCos, StSin, StDone} state_e;

    state_e                  state_q, state_d;
    logic [GapW-1:0]         gap_q, gap_d;
    logic [ADDR_WIDTH:0]     row_q, row_d, rows_q, rows_d, row_inc;
    logic                    after_cos_q, after_cos_d;
    logic                    fetch_q, fetch_d;
    logic [SRC_LATENCY-1:0]  pipe_q;
    logic [2*LO_WIDTH-1:0]   hold_q, row_data;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic                    astb_q, astb_d, cstb_q, cstb_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    err_q, err_d, abt_q, abt_d;
    logic [ADDR_WIDTH+1:0]   end_row;
    logic                    reject;

    function automatic logic [DATA_WIDTH-1:0] sext(input logic [LO_WIDTH-1:0] v);
        return DATA_WIDTH'(signed'(v));
    endfunction

    // Bypass covers SRC_LATENCY == STROBE_GAP, where capture and the COS load share an edge.
    assign row_data = pipe_q[SRC_LATENCY-1] ? bus.srcData : hold_q;
    assign row_inc  = row_q + (ADDR_WIDTH+1)'(1);
    assign end_row  = {2'b00, bus.firstRow} + {1'b0, bus.rowCount};
    assign reject   = (bus.rowCount == '0) || (end_row > (ADDR_WIDTH+2)'(ROW_CAPACITY));

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        row_d       = row_q;
        rows_d      = rows_q;
        after_cos_d = after_cos_q;
        fetch_d     = 1'b0;
        data_d      = data_q;
        src_d       = src_q;
        astb_d      = 1'b0;
        cstb_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        abt_d       = abt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        err_d       = 1'b0;
                        abt_d       = 1'b0;
                        busy_d      = 1'b1;
                        astb_d      = 1'b1;
                        state_d     = StAddr;
                        data_d      = '0;
                        data_d[DATA_WIDTH-1]   = bus.tableSelect;
                        data_d[ADDR_WIDTH-1:0] = bus.firstRow;
                        src_d       = '0;
                        fetch_d     = 1'b1;
                        row_d       = '0;
                        rows_d      = bus.rowCount;
                        after_cos_d = 1'b0;
                    end
                end
            end
            StAddr, StCos, StSin: begin
                state_d = StGap;
                gap_d   = GapW'(1);
            end
            StGap: begin
                if (gap_q != GapW'(STROBE_GAP)) begin
                    gap_d = gap_q + GapW'(1);
                end else if (after_cos_q) begin
                    state_d     = StSin;
                    cstb_d      = 1'b1;
                    after_cos_d = 1'b0;
                    data_d      = sext(hold_q[LO_WIDTH-1:0]);
                    row_d       = row_inc;
                    // Next row's read is issued on this SIN strobe; none after the last row.
                    if (row_inc < rows_q) begin
                        src_d   = row_inc[ADDR_WIDTH-1:0];
                        fetch_d = 1'b1;
                    end
                end else if (row_q == rows_q) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d     = StCos;
                    cstb_d      = 1'b1;
                    after_cos_d = 1'b1;
                    data_d      = sext(row_data[2*LO_WIDTH-1:LO_WIDTH]);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (busy_q && bus.abort) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            astb_d  = 1'b0;
            cstb_d  = 1'b0;
            done_d  = 1'b0;
            fetch_d = 1'b0;
            abt_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            gap_q       <= '0;
            row_q       <= '0;
            rows_q      <= '0;
            after_cos_q <= 1'b0;
            fetch_q     <= 1'b0;
            pipe_q      <= '0;
            hold_q      <= '0;
            data_q      <= '0;
            src_q       <= '0;
            astb_q      <= 1'b0;
            cstb_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            abt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            row_q       <= row_d;
            rows_q      <= rows_d;
            after_cos_q <= after_cos_d;
            fetch_q     <= fetch_d;
            pipe_q[0]   <= fetch_q;
            for (int i = 1; i < SRC_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (pipe_q[SRC_LATENCY-1]) begin
                hold_q <= bus.srcData;
            end
            data_q      <= data_d;
            src_q       <= src_d;
            astb_q      <= astb_d;
            cstb_q      <= cstb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            abt_q       <= abt_d;
        end
    end

    assign bus.srcAddr                      = src_q;
    assign bus.gpioData                     = data_q;
    assign bus.localOscillatorAddressStrobe = astb_q;
    assign bus.localOscillatorCsrStrobe     = cstb_q;
    assign bus.busy                         = busy_q;
    assign bus.done                         = done_q;
    assign bus.errorFlag                    = err_q;
    assign bus.abortedFlag                  = abt_q;
endmodule

// File: tb/tb_lo_table_loader.sv
// Scoreboard bench for lo_table_loader: two instances (gap 2 / latency 1, gap 3 / latency 3).
// Expected strobe events come from a row-level model of the transfer schedule.
module tb_lo_table_loader;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 18;
    localparam int unsigned AW = 10;
    localparam int Never = 32'h7fff_ffff;

    typedef struct {
        int          cyc;
        int          kind;   // 1 address strobe, 2 CSR strobe, 4 done
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    ev_t         q_a[$];
    ev_t         q_b[$];
    logic [35:0] rom_a[1024];
    logic [35:0] rom_b[1024];
    logic [35:0] a_p1, b_p1, b_p2, b_p3;
    logic [31:0] last_data[2];

    lo_table_loader_if #(.DATA_WIDTH(DW), .LO_WIDTH(LW), .ADDR_WIDTH(AW)) ia ();
    lo_table_loader_if #(.DATA_WIDTH(DW), .LO_WIDTH(LW), .ADDR_WIDTH(AW)) ib ();

    lo_table_loader #(
        .DATA_WIDTH(DW), .LO_WIDTH(LW), .ADDR_WIDTH(AW),
        .ROW_CAPACITY(1024), .STROBE_GAP(2), .SRC_LATENCY(1)
    ) dut_a (
        .clk(clk), .reset(rst_a), .bus(ia)
    );

    lo_table_loader #(
        .DATA_WIDTH(DW), .LO_WIDTH(LW), .ADDR_WIDTH(AW),
        .ROW_CAPACITY(1024), .STROBE_GAP(3), .SRC_LATENCY(3)
    ) dut_b (
        .clk(clk), .reset(rst_b), .bus(ib)
    );

    // Source memories with the configured read latency.
    always @(posedge clk) begin
        a_p1 <= rom_a[ia.srcAddr];
        b_p1 <= rom_b[ib.srcAddr];
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end
    assign ia.srcData = a_p1;
    assign ib.srcData = b_p3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [17:0] v);
        int s;
        s = int'(v);
        if (s >= 131072) s = s - 262144;
        return 32'(s);
    endfunction

    task automatic push(input int w, input ev_t e, input int cutoff);
        if (e.cyc <= cutoff) begin
            if (w == 0) q_a.push_back(e);
            else q_b.push_back(e);
        end
    endtask

    // Strobe k of a transfer started at c0 lands at c0+1+k*(g+1); events after cutoff never occur.
    task automatic model(input int w, input int c0, input int g, input bit tsel, input int first,
                         input int n, input int cutoff);
        ev_t         e;
        logic [35:0] row;
        int          p;
        p = g + 1;
        e.cyc  = c0 + 1;
        e.kind = 1;
        e.data = 32'(first);
        if (tsel) e.data[31] = 1'b1;
        push(w, e, cutoff);
        for (int r = 0; r < n; r++) begin
            row    = (w == 0) ? rom_a[r] : rom_b[r];
            e.kind = 2;
            e.cyc  = c0 + 1 + (2 * r + 1) * p;
            e.data = sx(row[35:18]);
            push(w, e, cutoff);
            e.cyc  = c0 + 1 + (2 * r + 2) * p;
            e.data = sx(row[17:0]);
            push(w, e, cutoff);
        end
        e.cyc  = c0 + (2 * n + 1) * p + 1;
        e.kind = 4;
        e.data = '0;
        push(w, e, cutoff);
    endtask

    task automatic mon(input int w, input logic as, input logic cs, input logic dn,
                       input logic bsy, input logic [31:0] d);
        ev_t        e;
        logic [2:0] k;
        int         qs;
        k  = {dn, cs, as};
        qs = (w == 0) ? q_a.size() : q_b.size();
        if (k != 3'b000) begin
            if (qs == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output dut%0d at cycle %0d: got kind %0d, want none",
                         w, cyc, k);
            end else begin
                if (w == 0) e = q_a.pop_front();
                else e = q_b.pop_front();
                check("evt_cycle", cyc, e.cyc);
                check("evt_kind", 32'(k), e.kind);
                if (e.kind != 4) check("evt_data", d, e.data);
                last_data[w] = d;
            end
        end else if (bsy) begin
            check("gap_hold", d, last_data[w]);
        end
    endtask

    always @(negedge clk)
        mon(0, ia.localOscillatorAddressStrobe, ia.localOscillatorCsrStrobe, ia.done, ia.busy,
            ia.gpioData);
    always @(negedge clk)
        mon(1, ib.localOscillatorAddressStrobe, ib.localOscillatorCsrStrobe, ib.done, ib.busy,
            ib.gpioData);

    task automatic to_cycle(input int x);
        while (cyc < x) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int w, input bit st, input bit ab, input bit tsel, input int first,
                         input int n);
        if (w == 0) begin
            ia.start = st; ia.abort = ab; ia.tableSelect = tsel;
            ia.firstRow = AW'(first); ia.rowCount = (AW+1)'(n);
        end else begin
            ib.start = st; ib.abort = ab; ib.tableSelect = tsel;
            ib.firstRow = AW'(first); ib.rowCount = (AW+1)'(n);
        end
        @(posedge clk);
        #1;
        ia.start = 1'b0; ia.abort = 1'b0;
        ib.start = 1'b0; ib.abort = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got timeout, want test end", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0, n, first;
        bit  tsel, valid;
        ia.start = 0; ia.abort = 0; ia.tableSelect = 0; ia.firstRow = '0; ia.rowCount = '0;
        ib.start = 0; ib.abort = 0; ib.tableSelect = 0; ib.firstRow = '0; ib.rowCount = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            rom_a[i] = 36'({$urandom, $urandom});
            rom_b[i] = 36'({$urandom, $urandom});
        end
        @(posedge clk);
        #1;
        to_cycle(3);
        rst_a = 1'b0;
        rst_b = 1'b0;
        check("reset_gpio", ia.gpioData, 32'h0);
        check("reset_src", 32'(ia.srcAddr), 32'h0);
        check("reset_ctl", 32'({ia.localOscillatorAddressStrobe, ia.localOscillatorCsrStrobe,
                                ia.busy, ia.done, ia.errorFlag, ia.abortedFlag}), 32'h0);
        to_cycle(4);

        // Basic transfer: rows {1,-1},{2,-2},{3,-3} to firstRow 5 of the PT table.
        rom_a[0] = {18'd1, 18'h3FFFF};
        rom_a[1] = {18'd2, 18'h3FFFE};
        rom_a[2] = {18'd3, 18'h3FFFD};
        c0 = cyc;
        model(0, c0, 2, 1'b1, 5, 3, Never);
        pulse(0, 1'b1, 1'b0, 1'b1, 5, 3);
        check("basic_busy_first", 32'(ia.busy), 32'd1);
        to_cycle(c0 + 21);
        check("basic_busy_last", 32'(ia.busy), 32'd1);
        to_cycle(c0 + 22);
        check("basic_done_busy", 32'({ia.done, ia.busy}), 32'b10);
        to_cycle(c0 + 24);

        // Rejects.
        c0 = cyc;
        pulse(0, 1'b1, 1'b0, 1'b0, 5, 0);
        check("rej_n0_err_busy", 32'({ia.errorFlag, ia.busy}), 32'b10);
        to_cycle(c0 + 4);
        check("rej_n0_idle", 32'(ia.busy), 32'd0);
        c0 = cyc;
        pulse(0, 1'b1, 1'b0, 1'b0, 1020, 5);
        check("rej_cap_err_busy", 32'({ia.errorFlag, ia.busy}), 32'b10);
        to_cycle(c0 + 4);
        check("rej_cap_idle", 32'(ia.busy), 32'd0);

        // Sign extension, and the valid start clears errorFlag.
        rom_a[0] = {18'h1FFFF, 18'h20000};
        c0 = cyc;
        model(0, c0, 2, 1'b0, 0, 1, Never);
        pulse(0, 1'b1, 1'b0, 1'b0, 0, 1);
        check("err_cleared", 32'(ia.errorFlag), 32'd0);
        to_cycle(c0 + 12);

        // Abort at cycle 8 of an N=3 run.
        rom_a[0] = {18'd1, 18'h3FFFF};
        c0 = cyc;
        model(0, c0, 2, 1'b1, 5, 3, c0 + 8);
        pulse(0, 1'b1, 1'b0, 1'b1, 5, 3);
        to_cycle(c0 + 8);
        pulse(0, 1'b0, 1'b1, 1'b0, 0, 0);
        check("abort_busy", 32'(ia.busy), 32'd0);
        check("abort_flag", 32'(ia.abortedFlag), 32'd1);
        to_cycle(c0 + 25);

        // Simultaneous start and abort in IDLE does nothing.
        c0 = cyc;
        pulse(0, 1'b1, 1'b1, 1'b1, 0, 2);
        check("startabort_busy", 32'(ia.busy), 32'd0);
        to_cycle(c0 + 4);
        check("startabort_flags", 32'({ia.busy, ia.abortedFlag}), 32'b01);

        // Reset at cycle 11 mid-transfer.
        c0 = cyc;
        model(0, c0, 2, 1'b0, 7, 3, c0 + 11);
        pulse(0, 1'b1, 1'b0, 1'b0, 7, 3);
        to_cycle(c0 + 11);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        check("midreset_gpio", ia.gpioData, 32'h0);
        check("midreset_src", 32'(ia.srcAddr), 32'h0);
        check("midreset_ctl", 32'({ia.localOscillatorAddressStrobe, ia.localOscillatorCsrStrobe,
                                   ia.busy, ia.done, ia.errorFlag, ia.abortedFlag}), 32'h0);
        to_cycle(c0 + 25);

        // Randomized transfers; one forced capacity overflow.
        for (int t = 0; t < 6; t++) begin
            n     = $urandom_range(2, 12);
            first = (t == 3) ? 1023 : $urandom_range(0, 1024 - n);
            tsel  = 1'($urandom);
            valid = (first + n <= 1024);
            for (int r = 0; r < n; r++) rom_a[r] = 36'({$urandom, $urandom});
            c0 = cyc;
            if (valid) model(0, c0, 2, tsel, first, n, Never);
            pulse(0, 1'b1, 1'b0, tsel, first, n);
            to_cycle(c0 + (2 * n + 1) * 3 + 3);
            check("rand_err", 32'(ia.errorFlag), 32'(!valid));
        end
        check("pending_a", 32'(q_a.size()), 32'd0);

        // Latency stress: full table, starts during busy are ignored.
        c0 = cyc;
        model(1, c0, 3, 1'b0, 0, 1024, Never);
        pulse(1, 1'b1, 1'b0, 1'b0, 0, 1024);
        for (int j = 0; j < 5; j++) begin
            to_cycle(c0 + 50 + j * 1500);
            pulse(1, 1'b1, 1'b0, 1'($urandom), $urandom_range(0, 1023), j == 0 ? 0 : j);
        end
        to_cycle(c0 + 8196);
        check("stress_busy_last", 32'(ib.busy), 32'd1);
        to_cycle(c0 + 8197);
        check("stress_done", 32'({ib.done, ib.busy, ib.errorFlag}), 32'b100);
        to_cycle(c0 + 8200);
        check("pending_b", 32'(q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lo_table_loader.md
# lo_table_loader

Sequencer that transfers a local-oscillator table from a local source memory into the local-oscillator GPIO write port (gpioData with address and CSR strobes). It runs in the system clock domain and is the initiator of that write protocol, so that firmware can reload the RF or PT LO rows with one start command. The block emits one address word, then two data words per row (cos, then sin), with fixed strobe spacing. Status outputs report busy, done, error and abort.

## Interface
- DATA_WIDTH, 32, GPIO word width
- LO_WIDTH, 18, signed LO sample width (≤ DATA_WIDTH)
- ADDR_WIDTH, 10, row index width
- ROW_CAPACITY, 1024, number of rows in the destination table
- STROBE_GAP, 2, idle cycles after every strobe (≥ SRC_LATENCY)
- SRC_LATENCY, 1, source read latency in cycles (1..3)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request, sampled only in IDLE
- tableSelect  in  1  0 = RF table, 1 = PT table
- firstRow  in  ADDR_WIDTH  first destination row
- rowCount  in  ADDR_WIDTH+1  number of rows N
- abort  in  1  stop the transfer
- srcAddr  out  ADDR_WIDTH  source row index
- srcData  in  2*LO_WIDTH  {cos, sin}, valid SRC_LATENCY cycles after srcAddr
- gpioData  out  DATA_WIDTH  word to the LO port
- localOscillatorAddressStrobe  out  1  address-word strobe
- localOscillatorCsrStrobe  out  1  data-word strobe
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- errorFlag  out  1  sticky; set by a rejected request
- abortedFlag  out  1  sticky; set by an abort

## Operation
- States: IDLE, ADDR, GAP, COS, SIN, DONE.
- start in IDLE checks the request. It is rejected when N==0 or firstRow+N > ROW_CAPACITY.
  - On reject: errorFlag is set, busy stays low, no strobe is issued, the FSM stays in IDLE.
  - On accept: errorFlag and abortedFlag are cleared and the FSM goes to ADDR.
- Address word: bit DATA_WIDTH-1 = tableSelect, bits [ADDR_WIDTH-1:0] = firstRow, all other bits 0.
- Data words: the LO_WIDTH value, sign-extended to DATA_WIDTH. For row r (0..N-1): the COS word is srcData[2*LO_WIDTH-1:LO_WIDTH], then the SIN word is srcData[LO_WIDTH-1:0].
- The LO port auto-increments its row after each SIN word. The loader never re-sends an address within a transfer.
- srcAddr = r is presented on the strobe cycle that precedes row r's COS strobe (the ADDR strobe, or the previous row's SIN strobe). srcData is captured into a holding register exactly SRC_LATENCY cycles later.
- Every strobe is followed by exactly STROBE_GAP cycles with both strobes low. After the gap of the last SIN strobe, the FSM goes to DONE for one cycle, then returns to IDLE.
- Strobes are single-cycle and mutually exclusive. gpioData is held stable from each strobe through its gap.
- start while busy is ignored.
- abort while busy:
  - If abort is high at cycle t: no strobe occurs at t+1 or later, busy is 0 at t+1, abortedFlag is set, and done does not pulse.
  - abort in IDLE has no effect.
  - If start and abort are high in the same IDLE cycle, abort wins: nothing starts.
- Reset, including mid-transfer: on the next cycle state is IDLE and all outputs are 0 (gpioData, srcAddr, strobes, busy, done, errorFlag, abortedFlag). A partially written table stays as written.

## Timing
- All outputs are registered.
- Let G = STROBE_GAP and N = rowCount, with start sampled at cycle 0. Strobe k (k = 0..2N) is at cycle 1+k·(G+1):
  - k = 0 is ADDR;
  - odd k is COS;
  - even k > 0 is SIN.
- busy is high in cycles 1..(2N+1)(G+1). done is high only at cycle (2N+1)(G+1)+1, and busy is low in that cycle.
- The earliest next start is the cycle after done.
- A rejected start sets errorFlag at cycle 1.
- Throughput: 2·(G+1) cycles per row.

## Test plan
- Basic transfer, G=2, SRC_LATENCY=1, N=3, firstRow=5, tableSelect=1, srcData rows {cos,sin} = {1,-1},{2,-2},{3,-3}:
  - address strobe at cycle 1 with gpioData=0x80000005;
  - CSR strobes at 4,7,10,13,16,19 with data 1, 0xFFFFFFFF, 2, 0xFFFFFFFE, 3, 0xFFFFFFFD;
  - done at 22.
- Rejects:
  - N=0 → errorFlag=1 at cycle 1, no strobe, busy never high;
  - firstRow=1020, N=5 (capacity 1024) → same response;
  - a following valid start clears errorFlag.
- Sign extension: cos=0x1FFFF, sin=0x20000 (LO_WIDTH=18) → words 0x0001FFFF and 0xFFFE0000.
- Abort at cycle 8 of the N=3 run → no strobes after cycle 7, busy=0 at 9, abortedFlag=1, no done pulse. A simultaneous start+abort in IDLE does nothing.
- Reset at cycle 11 mid-transfer → all outputs 0 at 12, no further strobes. A fresh start then completes normally.
- Latency stress, G=3, SRC_LATENCY=3, N=1024, firstRow=0 → every data word matches its source row, done at cycle 2049·4+1 = 8197, and start pulses during busy are ignored.
